// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: two per-source result FIFOs drained
// one entry per cycle onto a registered broadcast bus, round-robin on ties.
module cdb_arbiter #(
  parameter int ROB_BIT = 4,
  parameter int DEPTH   = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               rob_clear_up,
  input  logic               alu_valid,
  input  logic [ROB_BIT-1:0] alu_rob_entry,
  input  logic [31:0]        alu_value,
  input  logic               lsb_valid,
  input  logic [ROB_BIT-1:0] lsb_rob_entry,
  input  logic [31:0]        lsb_value,
  output logic               alu_full,
  output logic               lsb_full,
  output logic               cdb_valid,
  output logic [ROB_BIT-1:0] cdb_rob_entry,
  output logic [31:0]        cdb_value,
  output logic               cdb_src,
  output logic               err_overflow
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = ROB_BIT + 32;

  logic [EW-1:0]      mem_q [2][DEPTH];
  logic [EW-1:0]      mem_d [2][DEPTH];
  logic [PW-1:0]      wp_q [2];
  logic [PW-1:0]      wp_d [2];
  logic [PW-1:0]      rp_q [2];
  logic [PW-1:0]      rp_d [2];
  logic [CW-1:0]      cnt_q [2];
  logic [CW-1:0]      cnt_d [2];
  logic               last_q, last_d;
  logic               vld_q, vld_d;
  logic               src_q, src_d;
  logic               err_q, err_d;
  logic [ROB_BIT-1:0] tag_q, tag_d;
  logic [31:0]        val_q, val_d;

  logic [1:0]    push, ne, acc, pop;
  logic [EW-1:0] din [2];
  logic          gnt, gsrc;
  logic [EW-1:0] head;

  always_comb begin
    push    = {lsb_valid, alu_valid};
    din[0]  = {alu_rob_entry, alu_value};
    din[1]  = {lsb_rob_entry, lsb_value};
    ne[0]   = cnt_q[0] != '0;
    ne[1]   = cnt_q[1] != '0;
    gnt     = |ne;
    // on a tie the source that did not win last time goes first
    gsrc    = (&ne) ? ~last_q : ne[1];
    head    = mem_q[gsrc][rp_q[gsrc]];
  end

  always_comb begin
    mem_d  = mem_q;
    wp_d   = wp_q;
    rp_d   = rp_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    vld_d  = vld_q;
    src_d  = src_q;
    err_d  = err_q;
    tag_d  = tag_q;
    val_d  = val_q;
    acc    = '0;
    pop    = '0;
    if (rob_clear_up) begin
      for (int s = 0; s < 2; s++) begin
        wp_d[s]  = '0;
        rp_d[s]  = '0;
        cnt_d[s] = '0;
      end
      vld_d  = 1'b0;
      last_d = 1'b1;
    end else if (rdy_in) begin
      for (int s = 0; s < 2; s++) begin
        pop[s] = gnt && (gsrc == 1'(s));
        acc[s] = push[s] && (cnt_q[s] != CW'(DEPTH));
        if (push[s] && !acc[s])
          err_d = 1'b1;
        if (acc[s]) begin
          mem_d[s][wp_q[s]] = din[s];
          wp_d[s] = wp_q[s] + PW'(1);
        end
        if (pop[s])
          rp_d[s] = rp_q[s] + PW'(1);
        cnt_d[s] = cnt_q[s] + CW'(acc[s]) - CW'(pop[s]);
      end
      vld_d = gnt;
      if (gnt) begin
        tag_d  = head[EW-1:32];
        val_d  = head[31:0];
        src_d  = gsrc;
        last_d = gsrc;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      for (int s = 0; s < 2; s++) begin
        for (int i = 0; i < DEPTH; i++)
          mem_q[s][i] <= '0;
        wp_q[s]  <= '0;
        rp_q[s]  <= '0;
        cnt_q[s] <= '0;
      end
      last_q <= 1'b1;
      vld_q  <= 1'b0;
      src_q  <= 1'b0;
      err_q  <= 1'b0;
      tag_q  <= '0;
      val_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      vld_q  <= vld_d;
      src_q  <= src_d;
      err_q  <= err_d;
      tag_q  <= tag_d;
      val_q  <= val_d;
    end
  end

  assign alu_full      = cnt_q[0] >= CW'(DEPTH - 1);
  assign lsb_full      = cnt_q[1] >= CW'(DEPTH - 1);
  assign cdb_valid     = vld_q;
  assign cdb_rob_entry = tag_q;
  assign cdb_value     = val_q;
  assign cdb_src       = src_q;
  assign err_overflow  = err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_cdb_arbiter;

  localparam int RB = 4;
  localparam int D  = 4;

  logic          clk_in = 1'b0;
  logic          rst_in, rdy_in, rob_clear_up;
  logic          alu_valid, lsb_valid;
  logic [RB-1:0] alu_rob_entry, lsb_rob_entry;
  logic [31:0]   alu_value, lsb_value;
  logic          alu_full, lsb_full, cdb_valid, cdb_src, err_overflow;
  logic [RB-1:0] cdb_rob_entry;
  logic [31:0]   cdb_value;

  cdb_arbiter #(.ROB_BIT(RB), .DEPTH(D)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .rob_clear_up(rob_clear_up),
    .alu_valid(alu_valid), .alu_rob_entry(alu_rob_entry),
    .alu_value(alu_value),
    .lsb_valid(lsb_valid), .lsb_rob_entry(lsb_rob_entry),
    .lsb_value(lsb_value),
    .alu_full(alu_full), .lsb_full(lsb_full),
    .cdb_valid(cdb_valid), .cdb_rob_entry(cdb_rob_entry),
    .cdb_value(cdb_value), .cdb_src(cdb_src),
    .err_overflow(err_overflow)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [RB-1:0] tag;
    logic [31:0]   val;
  } ent_t;

  typedef struct packed {
    logic          v;
    logic [RB-1:0] tag;
    logic [31:0]   val;
    logic          src;
  } out_t;

  ent_t aq[$];
  ent_t lq[$];
  out_t exp_q[$];
  out_t m;
  logic m_last, m_err;
  int   n_pass = 0;
  int   n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic model_reset();
    aq.delete();
    lq.delete();
    m      = '0;
    m_last = 1'b1;
    m_err  = 1'b0;
  endtask

  // One clock: check flags, drive inputs, advance the model,
  // queue the bus state expected after the coming edge.
  task automatic cyc(input logic av, input logic [RB-1:0] at,
                     input logic [31:0] ad, input logic lv,
                     input logic [RB-1:0] lt, input logic [31:0] ld,
                     input logic rdy, input logic clr);
    int   na, nl;
    logic g;
    ent_t e;
    @(negedge clk_in);
    chk("alu_full", alu_full, aq.size() >= D - 1);
    chk("lsb_full", lsb_full, lq.size() >= D - 1);
    chk("err_overflow", err_overflow, m_err);
    alu_valid     = av;
    alu_rob_entry = at;
    alu_value     = ad;
    lsb_valid     = lv;
    lsb_rob_entry = lt;
    lsb_value     = ld;
    rdy_in        = rdy;
    rob_clear_up  = clr;
    if (clr) begin
      aq.delete();
      lq.delete();
      m.v    = 1'b0;
      m_last = 1'b1;
    end else if (rdy) begin
      na = aq.size();
      nl = lq.size();
      if (na > 0 && nl > 0) g = ~m_last;
      else g = (nl > 0);
      m.v = (na > 0 || nl > 0);
      if (m.v) begin
        e      = g ? lq.pop_front() : aq.pop_front();
        m.tag  = e.tag;
        m.val  = e.val;
        m.src  = g;
        m_last = g;
      end
      if (av) begin
        if (na == D) m_err = 1'b1;
        else aq.push_back('{at, ad});
      end
      if (lv) begin
        if (nl == D) m_err = 1'b1;
        else lq.push_back('{lt, ld});
      end
    end
    exp_q.push_back(m);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, '0, '0, 0, '0, '0, 1, 0);
  endtask

  task automatic both(input int n, input int base);
    for (int i = 0; i < n; i++)
      cyc(1, RB'(base + i), $urandom, 1, RB'(base + i + 8), $urandom, 1, 0);
  endtask

  initial begin
    out_t e;
    forever begin
      @(posedge clk_in);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cdb_valid", cdb_valid, e.v);
        chk("cdb_rob_entry", cdb_rob_entry, e.tag);
        chk("cdb_value", cdb_value, e.val);
        chk("cdb_src", cdb_src, e.src);
      end
    end
  end

  initial begin
    rst_in        = 1'b1;
    rdy_in        = 1'b1;
    rob_clear_up  = 1'b0;
    alu_valid     = 1'b0;
    lsb_valid     = 1'b0;
    alu_rob_entry = '0;
    lsb_rob_entry = '0;
    alu_value     = '0;
    lsb_value     = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("rst_cdb_valid", cdb_valid, 0);
    chk("rst_cdb_value", cdb_value, 0);
    idle(3);

    cyc(1, 4'd3, 32'h11, 0, '0, '0, 1, 0);
    idle(2);

    cyc(0, '0, '0, 0, '0, '0, 1, 1);
    cyc(1, 4'd1, 32'hA, 1, 4'd2, 32'hB, 1, 0);
    cyc(1, 4'd5, 32'hC, 1, 4'd6, 32'hD, 1, 0);
    idle(5);

    both(12, 0);
    idle(10);

    both(3, 2);
    cyc(0, '0, '0, 1, 4'd9, 32'h99, 1, 1);
    cyc(1, 4'd7, 32'h77, 1, 4'd8, 32'h88, 1, 0);
    idle(6);

    both(3, 4);
    repeat (4) cyc(1, 4'hE, $urandom, 1, 4'hF, $urandom, 0, 0);
    idle(10);

    both(2, 1);
    @(negedge clk_in);
    rst_in    = 1'b1;
    alu_valid = 1'b0;
    lsb_valid = 1'b0;
    rdy_in    = 1'b1;
    #1;
    chk("async_cdb_valid", cdb_valid, 0);
    chk("async_cdb_value", cdb_value, 0);
    chk("async_alu_full", alu_full, 0);
    chk("async_lsb_full", lsb_full, 0);
    chk("async_err", err_overflow, 0);
    model_reset();
    @(negedge clk_in);
    rst_in = 1'b0;
    idle(2);

    repeat (400)
      cyc(1'($urandom % 5 < 2), RB'($urandom), $urandom,
          1'($urandom % 5 < 2), RB'($urandom), $urandom,
          1'($urandom % 5 != 0), 1'($urandom % 40 == 0));
    idle(12);
    @(posedge clk_in);
    #3;
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Common-data-bus arbiter that merges the ALU result stream (from the reservation station) and the load/store-buffer result stream onto one broadcast bus consumed by ROB, RS and LSB. Each source gets a small FIFO so a result is never lost when both complete in the same cycle. A round-robin scheduler drains one result per cycle. Almost-full flags throttle the producers: the RS stops dispatching and the LSB stops completing.

## Interface
- ROB_BIT, 4, width of ROB entry tags
- DEPTH, 4, entries per source FIFO; power of two, >= 2

- clk_in  in  1  system clock
- rst_in  in  1  reset, asynchronous, active-high
- rdy_in  in  1  global ready; all state frozen when low
- rob_clear_up  in  1  synchronous flush from ROB on mispredict
- alu_valid  in  1  ALU result present this cycle
- alu_rob_entry  in  ROB_BIT  destination ROB tag of ALU result
- alu_value  in  32  ALU result value
- lsb_valid  in  1  LSB result present this cycle
- lsb_rob_entry  in  ROB_BIT  destination ROB tag of LSB result
- lsb_value  in  32  LSB result value
- alu_full  out  1  ALU FIFO count >= DEPTH-1; RS must not dispatch
- lsb_full  out  1  LSB FIFO count >= DEPTH-1; LSB must not complete
- cdb_valid  out  1  broadcast valid
- cdb_rob_entry  out  ROB_BIT  broadcast ROB tag
- cdb_value  out  32  broadcast value
- cdb_src  out  1  0 = ALU, 1 = LSB
- err_overflow  out  1  sticky: a push arrived while a FIFO was at DEPTH

## Operation
- Two identical circular FIFOs, each DEPTH x (ROB_BIT+32).
  - Read and write pointers are log2(DEPTH) bits and wrap naturally.
  - Count is log2(DEPTH)+1 bits.
- Push: `x_valid` && rdy_in && !rob_clear_up.
  - Writes at the write pointer when count < DEPTH.
  - If count == DEPTH, the entry is dropped and err_overflow is set.
- Arbitration each cycle, rdy_in high, no flush:
  - Neither FIFO non-empty: no grant.
  - One FIFO non-empty: grant it.
  - Both non-empty: grant the source opposite last_grant.
  - The granted head is popped and loaded into the cdb_* registers with cdb_valid=1; last_grant takes the grantee.
  - With no grant, cdb_valid <= 0 and the tag, value and src registers hold.
- Push and pop on the same FIFO in the same cycle: count unchanged; both pointers advance.
  - An empty FIFO cannot push and pop in one cycle, because the pop reads the pre-edge head. There is no bypass.
- alu_full and lsb_full are combinational from count (>= DEPTH-1).
  - This guarantees room for the one result already in flight in the 1-cycle ALU.
- rob_clear_up (takes priority over rdy_in):
  - Pointers and counts go to 0, cdb_valid <= 0, last_grant <= 1.
  - Pushes in that cycle are discarded.
  - err_overflow is preserved.
- rdy_in low, no flush: no push, no pop; all registers and outputs hold, including cdb_valid.
- Reset values (asynchronous, immediate):
  - cdb_valid=0, cdb_rob_entry=0, cdb_value=0, cdb_src=0, err_overflow=0.
  - last_grant=1, so the ALU wins the first tie.
  - All pointers and counts are 0, so alu_full=0 and lsb_full=0.

## Timing
- Latency: an input valid sampled at edge E0 (enqueue) can reach cdb_valid at earliest after edge E1, i.e. 1 cycle of queueing.
- Throughput: 1 broadcast per cycle total.
  - Under a sustained tie, each source gets every other cycle.
  - Worst-case wait for a head entry is 1 cycle of contention.
- FIFO order is strict per source; no ordering is guaranteed between sources.
- cdb_* outputs are registered; alu_full and lsb_full are combinational from registered counts (no input-to-output paths).
- Asserting rst_in mid-stream clears everything at once, without waiting for a clock edge; in-flight entries are lost.

## Test plan
- Reset release, both sources idle 3 cycles -> cdb_valid=0, alu_full=0, lsb_full=0, err_overflow=0.
- alu_valid tag 3 value 0x11 at E0 -> after E1 cdb_valid=1, cdb_rob_entry=3, cdb_value=0x11, cdb_src=0; after E2 cdb_valid=0.
- Simultaneous ALU (tag 1, 0xA) and LSB (tag 2, 0xB) at E0, then again (tags 5 and 6) at E1 -> broadcasts after E1..E4 in order tags 1 (src 0), 2 (src 1), 5 (src 0), 6 (src 1).
- Fill the LSB FIFO with DEPTH-1 pushes while the ALU queue also holds entries -> lsb_full=1. A forced DEPTH-th push is accepted; a DEPTH+1-th push is dropped and err_overflow=1, staying set until rst_in.
- Queue 3 ALU entries, assert rob_clear_up together with lsb_valid -> next cycle cdb_valid=0, both counts 0, the LSB entry is not broadcast, and the next tie grants the ALU.
- Hold rdy_in low for 4 cycles with cdb_valid=1 and entries queued -> outputs frozen, no pops. After rdy_in rises, the remaining entries drain in round-robin order with none lost.
